// File: rtl/bus_arbiter_if.sv
`timescale 1ns/1ps
// Shared memory-bus signals between the fetch/data arbiter (master) and the
// bus target (slave).
interface bus_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, be, input ready, rdata);
    modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/bus_arbiter.sv
`timescale 1ns/1ps
// Arbitrates one memory bus between the instruction-fetch and load/store
// requesters. Data has priority, limited to DATA_BURST_MAX grants while a fetch waits.
module bus_arbiter #(
    parameter int unsigned DATA_BURST_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 f_req,
    input  logic [31:0]          f_addr,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [31:0]          d_addr,
    input  logic [31:0]          d_wdata,
    input  logic [3:0]           d_be,
    bus_arbiter_if.master        bus,
    output logic                 f_done,
    output logic                 d_done,
    output logic [31:0]          rdata,
    output logic                 stopfetch
);
    localparam logic [2:0] BURST_LIMIT = 3'(DATA_BURST_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DATA  = 2'b10
    } state_t;

    state_t     state, next_state;
    logic [2:0] streak, next_streak;
    logic       arbitrate;
    logic       fetch_complete;
    logic       data_complete;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            streak <= 3'd0;
        end else begin
            state  <= next_state;
            streak <= next_streak;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state     = IDLE;
        next_streak    = streak;
        arbitrate      = 1'b0;
        fetch_complete = 1'b0;
        data_complete  = 1'b0;
        bus.req        = 1'b0;
        bus.we         = 1'b0;
        bus.addr       = 32'h0;
        bus.wdata      = 32'h0;
        bus.be         = 4'h0;

        case (state)
            IDLE: arbitrate = 1'b1;
            FETCH: begin
                bus.req  = 1'b1;
                bus.addr = f_addr;
                bus.be   = 4'hF;
                if (bus.ready) begin
                    fetch_complete = 1'b1;
                    arbitrate      = 1'b1;
                end else if (f_req) begin
                    next_state = FETCH;
                end
            end
            DATA: begin
                bus.req   = 1'b1;
                bus.we    = d_we;
                bus.addr  = d_addr;
                bus.wdata = d_wdata;
                bus.be    = d_be;
                // A data transfer cannot be abandoned once on the bus.
                if (bus.ready) begin
                    data_complete = 1'b1;
                    arbitrate     = 1'b1;
                end else begin
                    next_state = DATA;
                end
            end
            default: next_state = IDLE;
        endcase

        if (arbitrate) begin
            if (d_req && (streak < BURST_LIMIT || !f_req)) begin
                next_state  = DATA;
                next_streak = !f_req ? 3'd0 : (streak == 3'd7) ? 3'd7 : streak + 3'd1;
            end else if (f_req) begin
                next_state  = FETCH;
                next_streak = 3'd0;
            end else begin
                next_state  = IDLE;
                next_streak = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_done <= 1'b0;
            d_done <= 1'b0;
            rdata  <= 32'h0;
        end else begin
            f_done <= fetch_complete;
            d_done <= data_complete;
            if (fetch_complete || (data_complete && !d_we))
                rdata <= bus.rdata;
        end
    end

    assign stopfetch = d_req || (state == DATA);
endmodule

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for bus_arbiter: a cycle model predicts bus outputs and
// queues expected done/rdata results, popped and compared after each edge.
module tb_bus_arbiter;
    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        f_req, d_req, d_we;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        f_done, d_done, stopfetch;
    logic [31:0] rdata;

    bus_arbiter_if bus();

    bus_arbiter #(.DATA_BURST_MAX(BURST)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .bus       (bus),
        .f_done    (f_done),
        .d_done    (d_done),
        .rdata     (rdata),
        .stopfetch (stopfetch)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_FETCH, M_DATA} m_state_t;
    typedef struct packed {
        logic        f;
        logic        d;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    m_state_t    m_state;
    int          m_streak;
    logic [31:0] m_rdata;
    logic [31:0] saved;
    int          starve;
    int          tests;
    int          fails;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [70:0] bus_vec();
        return {bus.req, bus.we, bus.addr, bus.wdata, bus.be, stopfetch};
    endfunction

    function automatic logic [70:0] exp_bus();
        logic [69:0] v;
        case (m_state)
            M_FETCH: v = {1'b1, 1'b0, f_addr, 32'h0, 4'hF};
            M_DATA:  v = {1'b1, d_we, d_addr, d_wdata, d_be};
            default: v = '0;
        endcase
        return {v, d_req | (m_state == M_DATA)};
    endfunction

    // 0 idle, 1 fetch, 2 data; fetch and data addresses are always kept distinct.
    function automatic int obs_kind();
        if (!bus.req) return 0;
        if (bus.addr == f_addr) return 1;
        return 2;
    endfunction

    task automatic predict();
        exp_t     e;
        bit       arb;
        m_state_t nxt;
        e   = '{f: 1'b0, d: 1'b0, rdata: m_rdata};
        arb = 1'b0;
        nxt = M_IDLE;
        case (m_state)
            M_IDLE: arb = 1'b1;
            M_FETCH:
                if (bus.ready) begin
                    e.f = 1'b1; e.rdata = bus.rdata; arb = 1'b1;
                end else if (f_req) nxt = M_FETCH;
            M_DATA:
                if (bus.ready) begin
                    e.d = 1'b1; arb = 1'b1;
                    if (!d_we) e.rdata = bus.rdata;
                end else nxt = M_DATA;
            default: nxt = M_IDLE;
        endcase
        if (arb) begin
            if (d_req && (m_streak < BURST || !f_req)) begin
                nxt      = M_DATA;
                m_streak = f_req ? ((m_streak >= 7) ? 7 : m_streak + 1) : 0;
            end else begin
                nxt      = f_req ? M_FETCH : M_IDLE;
                m_streak = 0;
            end
        end
        exp_q.push_back(e);
        m_state = nxt;
        m_rdata = e.rdata;
    endtask

    // Inputs are already applied; checks this cycle, steps one edge, checks results.
    task automatic cycle();
        int   pre_obs;
        logic pre_f, pre_rdy;
        exp_t e;
        #1;
        check("bus_out", bus_vec(), exp_bus());
        if (m_state == M_IDLE) check("idle_bus_req", bus.req, 1'b0);
        pre_obs = obs_kind();
        pre_f   = f_req;
        pre_rdy = bus.ready;
        predict();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else begin
            e = exp_q.pop_front();
            check("done_rdata", {f_done, d_done, rdata}, e);
        end
        check("done_excl", f_done & d_done, 1'b0);
        if (pre_obs == 0 || pre_rdy) begin
            if (obs_kind() == 2 && pre_f) begin
                starve++;
                check("fetch_starve", starve <= BURST, 1'b1);
            end else starve = 0;
        end
    endtask

    task automatic do_reset_pulse();
        reset_n = 1'b0;
        #1;
        m_state  = M_IDLE;
        m_streak = 0;
        m_rdata  = 32'h0;
        starve   = 0;
        exp_q.delete();
        check("rst_bus", bus_vec(), exp_bus());
        check("rst_done", {f_done, d_done, rdata}, 0);
        @(posedge clk);
        #1;
        check("rst_hold", {bus.req, f_done, d_done, rdata}, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic quiet();
        f_req = 1'b0; d_req = 1'b0; bus.ready = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tests = 0; fails = 0; starve = 0;
        f_req = 0; f_addr = 32'h0; d_req = 0; d_we = 0;
        d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        bus.ready = 1'b0; bus.rdata = 32'h0;
        do_reset_pulse();
        cycle();

        // Plain fetch completing on its third bus cycle; f_req drops in that cycle.
        f_req = 1'b1; f_addr = 32'h100; cycle();
        for (int i = 0; i < 3; i++) begin
            bus.ready = (i == 2); bus.rdata = 32'hDEADBEEF;
            if (i == 2) f_req = 1'b0;
            #1;
            check("fetch_addr", {bus.addr, bus.be}, {32'h100, 4'hF});
            cycle();
        end
        check("fetch_done", {f_done, rdata}, {1'b1, 32'hDEADBEEF});
        quiet(); cycle();

        // Simultaneous requests: store first, then fetch with no idle gap.
        f_req = 1'b1; f_addr = 32'h300; d_req = 1'b1; d_we = 1'b1;
        d_addr = 32'h2000; d_wdata = 32'hA5A50F0F; d_be = 4'h3;
        cycle();
        bus.ready = 1'b1; bus.rdata = 32'h11112222; d_req = 1'b0;
        #1;
        check("store_bus", {stopfetch, bus.we, bus.addr, bus.be}, {1'b1, 1'b1, 32'h2000, 4'h3});
        cycle();
        check("store_done", {d_done, rdata}, {1'b1, 32'hDEADBEEF});
        bus.ready = 1'b0;
        #1;
        check("store_then_fetch", {bus.req, bus.addr}, {1'b1, 32'h300});
        cycle();
        bus.ready = 1'b1; bus.rdata = 32'h33334444; f_req = 1'b0; cycle();
        quiet(); cycle();

        // Continuous data traffic with a waiting fetch: DDDDF DDDDF.
        f_req = 1'b1; f_addr = 32'h400; d_req = 1'b1; d_we = 1'b0;
        d_addr = 32'h2100; d_be = 4'hF; bus.ready = 1'b1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            bus.rdata = $urandom;
            #1;
            check("burst_seq", obs_kind(), (i % 5 == 4) ? 1 : 2);
            cycle();
        end
        // d_req withdrawn mid-transfer: the transfer still has to finish.
        quiet(); cycle();
        bus.ready = 1'b1; bus.rdata = 32'hCAFEF00D; cycle();
        quiet(); cycle();

        // Fetch flush, then a stale bus_ready while idle.
        f_req = 1'b1; f_addr = 32'h500; cycle();
        cycle();
        f_req = 1'b0; cycle();
        check("abort", {bus.req, f_done}, 0);
        saved = m_rdata;
        bus.ready = 1'b1; bus.rdata = 32'hBAD0BAD0; cycle();
        check("idle_ready", {f_done, d_done, rdata}, {2'b00, saved});
        quiet(); cycle();

        // Reset during a pending data transfer with the streak built up.
        f_req = 1'b1; f_addr = 32'h600; d_req = 1'b1; d_we = 1'b0;
        d_addr = 32'h2200; d_be = 4'hF; bus.ready = 1'b1;
        repeat (3) cycle();
        bus.ready = 1'b0; cycle();
        do_reset_pulse();
        bus.ready = 1'b1;
        cycle();
        check("rst_regrant", obs_kind(), 2);
        repeat (5) cycle();
        f_req = 1'b0; d_req = 1'b0; cycle();
        quiet(); cycle();

        // Random traffic under the requester protocols.
        for (int c = 0; c < 10000; c++) begin
            if (f_done) f_req = 1'($urandom_range(0, 1));
            else if (f_req) f_req = ($urandom_range(0, 15) != 0);
            else f_req = ($urandom_range(0, 2) == 0);
            if (!f_req || f_done) f_addr = 32'h1000 | ($urandom & 32'h0FFC);
            if (d_done || !d_req) begin
                d_req   = d_done ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'h2000 | ($urandom & 32'h0FFC);
                d_wdata = $urandom;
                d_be    = 4'($urandom_range(0, 15));
            end
            bus.ready = 1'($urandom_range(0, 1));
            bus.rdata = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter DATA_BURST_MAX, default 4: maximum consecutive data grants while a fetch is pending; legal range 1..7.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 f_req  in  1  fetch requester wants an instruction word; may drop before completion (flush).
REQ-005 f_addr  in  32  fetch address, stable while f_req high.
REQ-006 d_req  in  1  load/store requester wants a transfer; held high until d_done.
REQ-007 d_we  in  1  1 = store, 0 = load; stable while d_req high.
REQ-008 d_addr / d_wdata  in  32 each  data address / store data.
REQ-009 d_be  in  4  byte enables for data transfer.
REQ-010 bus_ready  in  1  bus completes the current transfer this cycle.
REQ-011 bus_rdata  in  32  bus read data, valid with bus_ready.
REQ-012 bus_req  out  1  transfer active on bus.
REQ-013 bus_we / bus_addr / bus_wdata / bus_be  out  1/32/32/4  muxed transfer attributes.
REQ-014 f_done / d_done  out  1 each  one-cycle completion pulses.
REQ-015 rdata  out  32  registered read data, valid while f_done or d_done high.
REQ-016 stopfetch  out  1  tells the fetch state machine not to start a new bus fetch.

Function
REQ-017 FSM states: IDLE, FETCH, DATA; encoding 2'b00, 2'b01, 2'b10; 2'b11 shall recover to IDLE next cycle.
REQ-018 Arbitration (in IDLE, and on completion in FETCH/DATA): if d_req and (streak < DATA_BURST_MAX or !f_req) -> DATA; else if f_req -> FETCH; else -> IDLE.
REQ-019 streak: 3-bit counter; +1 (saturating at 7) on each DATA grant while f_req high; cleared on FETCH grant or on any arbitration with f_req low.
REQ-020 IDLE: bus_req=0, bus_we=0, bus_be=0, bus_addr/bus_wdata=0.
REQ-021 FETCH: bus_req=1, bus_addr=f_addr, bus_we=0, bus_be=4'hF, bus_wdata=0.
REQ-022 DATA: bus_req=1, bus_addr=d_addr, bus_we=d_we, bus_be=d_be, bus_wdata=d_wdata.
REQ-023 Bus outputs combinational from state and requester inputs; no added latency.
REQ-024 bus_ready in FETCH/DATA completes the transfer; the state is re-arbitrated the same edge, so back-to-back transfers have zero idle cycles.
REQ-025 On completion edge: rdata <= bus_rdata (loads and fetches only; stores leave rdata unchanged), f_done or d_done <= 1 for exactly one cycle.
REQ-026 bus_ready in IDLE shall be ignored: no done pulse, no rdata update.
REQ-027 f_req low in FETCH without bus_ready: abort, go IDLE next edge, no f_done; a subsequent stale bus_ready is ignored per REQ-026.
REQ-028 f_req low and bus_ready high in the same FETCH cycle: the transfer completes and f_done pulses.
REQ-029 d_req low in DATA before completion is a protocol violation; the block shall stay in DATA until bus_ready.
REQ-030 stopfetch = d_req or (state == DATA); combinational.
REQ-031 f_done and d_done shall never be high in the same cycle.

Reset
REQ-032 reset_n low: state=IDLE, streak=0, rdata=0, f_done=0, d_done=0, immediately and asynchronously.
REQ-033 All outputs take IDLE values (REQ-020) while reset_n is low; stopfetch follows d_req.
REQ-034 Reset asserted mid-transfer abandons it without a done pulse; the first arbitration occurs on the first rising edge after release.

Verification
REQ-035 f_req=1, f_addr=0x100, bus_ready on the 3rd FETCH cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x100, bus_be=F; next cycle f_done=1, rdata=0xDEADBEEF.
REQ-036 f_req and d_req (store, d_addr=0x2000, d_be=4'h3) rise together -> DATA granted first, stopfetch=1, bus_we=1; after bus_ready, FETCH follows with no IDLE cycle.
REQ-037 d_req held continuously with f_req high, bus_ready every cycle, DATA_BURST_MAX=4 -> 4 data transfers, then 1 fetch, then data resumes.
REQ-038 FETCH active, f_req drops with bus_ready=0 -> IDLE next cycle, no f_done; bus_ready pulse in IDLE -> no done, rdata unchanged.
REQ-039 reset_n pulsed low during DATA with bus_ready pending -> bus_req=0, d_done never asserted, streak=0; after release, d_req re-grants DATA.
REQ-040 Random f_req/d_req/bus_ready for 10k cycles -> f_done/d_done never coincident, bus_req=0 in every IDLE cycle, no fetch waits more than DATA_BURST_MAX data transfers.
